// File: rtl/expgob_sched.sv
// -----------------------------------------------------------------------------
// expgob_sched
//
// Round-robin scheduler in front of one shared Exp-Golomb (k=0) serial
// encoder. One requester at a time is granted, its 8-bit symbol is loaded into
// the encoder with a one-cycle active-low start pulse, and the serial code
// bits that come back (MSB first) are collected into a right-aligned code
// word. The collected word is checked against the symbol: the length must be
// 2*floor(log2(dt+1))+1 and the value must equal dt+1. A result is then
// offered on a valid/ready handshake.
//
// Ports
//   clk, rst_n        clock (rising edge) / asynchronous active-low reset
//   req_valid_i       per-requester symbol valid               [N_REQ]
//   req_dt_i          per-requester symbol, k in [8k+7:8k]     [N_REQ*8]
//   req_ready_o       one-hot accept strobe (one cycle)        [N_REQ]
//   enc_dt_o          symbol driven to the encoder             [8]
//   enc_start_n_o     active-low one-cycle encoder load pulse
//   enc_busy_i        encoder busy; enc_cod_i valid while high
//   enc_cod_i         serial code bit, MSB first
//   res_valid_o       result valid, held until res_ready_i
//   res_ready_i       result accept
//   res_id_o          granted requester index                  [3]
//   res_code_o        collected code, right-aligned            [17]
//   res_len_o         number of collected bits, 0..17          [5]
//   res_err_o         job failed (timeout, overflow or bad code)
// -----------------------------------------------------------------------------
module expgob_sched #(
   parameter int N_REQ   = 4,  // number of requesters, 2..8
   parameter int TIMEOUT = 4   // max WAIT cycles before the first busy bit
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid_i,
   input  logic [N_REQ*8-1:0] req_dt_i,
   output logic [N_REQ-1:0]   req_ready_o,
   output logic [7:0]         enc_dt_o,
   output logic               enc_start_n_o,
   input  logic               enc_busy_i,
   input  logic               enc_cod_i,
   output logic               res_valid_o,
   input  logic               res_ready_i,
   output logic [2:0]         res_id_o,
   output logic [16:0]        res_code_o,
   output logic [4:0]         res_len_o,
   output logic               res_err_o
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [4:0] MAX_LEN = 5'd17;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      SHIFT,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    last_grant_q, last_grant_d;
   logic [2:0]    id_q, id_d;
   logic [7:0]    dt_q, dt_d;
   logic [16:0]   code_q, code_d;
   logic [4:0]    len_q, len_d;
   logic          err_q, err_d;
   logic [TW-1:0] wait_q, wait_d;

   // Requester vectors padded to the full 8-requester width so that the
   // 3-bit grant index can select into them for any N_REQ.
   logic [7:0]    valid_pad;
   logic [63:0]   dt_pad;
   logic [3:0]    rr_cand;
   logic [2:0]    grant_idx;
   logic          grant_found;

   // Code check of the collected word against the latched symbol.
   logic [8:0]    dt_plus1;
   logic [3:0]    dt_log2;
   logic          chk_fail;

   assign valid_pad = 8'(req_valid_i);
   assign dt_pad    = 64'(req_dt_i);

   function automatic logic [3:0] floor_log2(input logic [8:0] x);
      floor_log2 = '0;
      for (int b = 0; b < 9; b++) begin
         if (x[b]) floor_log2 = 4'(b);
      end
   endfunction

   assign dt_plus1 = {1'b0, dt_q} + 9'd1;
   assign dt_log2  = floor_log2(dt_plus1);
   // Expected length is 2*floor(log2(dt+1))+1, i.e. {log2, 1'b1}.
   assign chk_fail = (len_q != {dt_log2, 1'b1}) || (code_q != {8'b0, dt_plus1});

   // Round-robin search: first valid requester strictly after last_grant,
   // wrapping around, so last_grant itself has lowest priority.
   always_comb begin
      // NOTE: every variable driven here gets a default before any branch,
      // otherwise a path that skips the assignment would infer a latch.
      grant_found = 1'b0;
      grant_idx   = '0;
      rr_cand     = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         rr_cand = 4'(last_grant_q) + 4'(i);
         if (rr_cand >= 4'(N_REQ)) rr_cand = rr_cand - 4'(N_REQ);
         if (!grant_found && valid_pad[rr_cand[2:0]]) begin
            grant_found = 1'b1;
            grant_idx   = rr_cand[2:0];
         end
      end
   end

   // Next-state and control outputs.
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      id_d          = id_q;
      dt_d          = dt_q;
      code_d        = code_q;
      len_d         = len_q;
      err_d         = err_q;
      wait_d        = wait_q;
      enc_start_n_o = 1'b1;
      req_ready_o   = '0;

      case (state_q)
         IDLE: begin
            // rst_n gates the strobe so it stays low while reset is applied.
            if (grant_found && rst_n) begin
               for (int k = 0; k < N_REQ; k++) begin
                  if (grant_idx == 3'(k)) req_ready_o[k] = 1'b1;
               end
               id_d    = grant_idx;
               dt_d    = dt_pad[{grant_idx, 3'b000} +: 8];
               code_d  = '0;
               len_d   = '0;
               err_d   = 1'b0;
               wait_d  = '0;
               state_d = START;
            end
         end

         START: begin
            enc_start_n_o = 1'b0;
            state_d       = WAIT;
         end

         WAIT: begin
            if (enc_busy_i) begin
               code_d  = {code_q[15:0], enc_cod_i};
               len_d   = len_q + 5'd1;
               state_d = SHIFT;
            end else if (wait_q == TW'(TIMEOUT - 1)) begin
               // Encoder never answered: fail with an empty code.
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               wait_d = wait_q + TW'(1);
            end
         end

         SHIFT: begin
            if (!enc_busy_i) begin
               err_d   = chk_fail;
               state_d = DONE;
            end else if (len_q == MAX_LEN) begin
               // An 18th bit cannot be a legal 8-bit symbol code; keep the
               // first 17 bits and drop the rest.
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               code_d = {code_q[15:0], enc_cod_i};
               len_d  = len_q + 5'd1;
            end
         end

         DONE: begin
            if (res_ready_i) begin
               last_grant_d = id_q;
               state_d      = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 3'(N_REQ - 1);
         id_q         <= '0;
         dt_q         <= '0;
         code_q       <= '0;
         len_q        <= '0;
         err_q        <= 1'b0;
         wait_q       <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // values from before this edge, independent of statement order.
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         dt_q         <= dt_d;
         code_q       <= code_d;
         len_q        <= len_d;
         err_q        <= err_d;
         wait_q       <= wait_d;
      end
   end

   assign enc_dt_o    = dt_q;
   assign res_valid_o = (state_q == DONE);
   assign res_id_o    = id_q;
   assign res_code_o  = code_q;
   assign res_len_o   = len_q;
   assign res_err_o   = err_q;

endmodule

// File: tb/tb_expgob_sched.sv
// -----------------------------------------------------------------------------
// tb_expgob_sched
//
// Self-checking bench for expgob_sched. A behavioural encoder model answers
// each start pulse with an Exp-Golomb bit stream (correct or deliberately
// faulty), and a reference model predicts the round-robin grant and the
// collected code, length and error flag from the symbol and the bit stream.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_expgob_sched;

   localparam int N_REQ   = 4;
   localparam int TIMEOUT = 4;

   typedef enum int {M_OK, M_SILENT, M_LONG, M_BAD_PREFIX, M_BAD_SUFFIX} enc_mode_t;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [N_REQ-1:0]   req_valid_i = '0;
   logic [N_REQ*8-1:0] req_dt_i = '0;
   logic [N_REQ-1:0]   req_ready_o;
   logic [7:0]         enc_dt_o;
   logic               enc_start_n_o;
   logic               enc_busy_i = 1'b0;
   logic               enc_cod_i = 1'b0;
   logic               res_valid_o;
   logic               res_ready_i = 1'b0;
   logic [2:0]         res_id_o;
   logic [16:0]        res_code_o;
   logic [4:0]         res_len_o;
   logic               res_err_o;

   int n_checks = 0;
   int n_fail   = 0;
   int model_last = N_REQ - 1;
   bit enc_bits[$];

   expgob_sched #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid_i  (req_valid_i),
      .req_dt_i     (req_dt_i),
      .req_ready_o  (req_ready_o),
      .enc_dt_o     (enc_dt_o),
      .enc_start_n_o(enc_start_n_o),
      .enc_busy_i   (enc_busy_i),
      .enc_cod_i    (enc_cod_i),
      .res_valid_o  (res_valid_o),
      .res_ready_i  (res_ready_i),
      .res_id_o     (res_id_o),
      .res_code_o   (res_code_o),
      .res_len_o    (res_len_o),
      .res_err_o    (res_err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got hang required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int floor_log2(input int x);
      int nb = 0;
      while ((1 << (nb + 1)) <= x) nb++;
      return nb;
   endfunction

   // Round-robin reference: first set bit after the previous grant, wrapping.
   function automatic int model_pick(input logic [N_REQ-1:0] mask);
      for (int s = 1; s <= N_REQ; s++) begin
         int c = (model_last + s) % N_REQ;
         if (mask[c]) return c;
      end
      return -1;
   endfunction

   // Bit stream the encoder model emits for a symbol in a given mode.
   function automatic void build_bits(input logic [7:0] dt, input enc_mode_t mode);
      int x  = int'(dt) + 1;
      int nb = floor_log2(x);
      int pz = (mode == M_BAD_PREFIX) ? nb + 1 : nb;
      enc_bits.delete();
      if (mode == M_SILENT) return;
      for (int i = 0; i < pz; i++) enc_bits.push_back(1'b0);
      for (int b = nb; b >= 0; b--) enc_bits.push_back(x[b]);
      if (mode == M_BAD_SUFFIX) enc_bits[enc_bits.size()-1] = !enc_bits[enc_bits.size()-1];
      if (mode == M_LONG) while (enc_bits.size() < 18) enc_bits.push_back(1'($urandom_range(0, 1)));
   endfunction

   task automatic check_reset_outputs();
      check("rst_ready",   req_ready_o,   0);
      check("rst_start_n", enc_start_n_o, 1);
      check("rst_enc_dt",  enc_dt_o,      0);
      check("rst_valid",   res_valid_o,   0);
      check("rst_id",      res_id_o,      0);
      check("rst_code",    res_code_o,    0);
      check("rst_len",     res_len_o,     0);
      check("rst_err",     res_err_o,     0);
   endtask

   // One complete job: grant, start pulse, encoder answer, result, handshake.
   // Called at a falling edge with the DUT in IDLE; returns likewise.
   task automatic run_job(input logic [N_REQ-1:0] mask, input enc_mode_t mode,
                          input int delay, input int stall);
      int          exp_id;
      logic [7:0]  dt;
      int          x, nb, n, elen;
      logic [16:0] ecode;
      bit          eerr;
      bit          got;

      exp_id = model_pick(mask);
      if (exp_id < 0) return;
      dt = req_dt_i[exp_id*8 +: 8];
      req_valid_i = mask;
      #1;
      got = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (req_ready_o != '0) begin
            got = 1'b1;
            break;
         end
         @(negedge clk); #1;
      end
      check("grant_seen", 32'(got), 1);
      if (!got) begin
         req_valid_i = '0;
         return;
      end
      check("grant_onehot", 32'(req_ready_o), 32'(1) << exp_id);

      @(negedge clk); #1;
      check("start_pulse",  enc_start_n_o, 0);
      check("start_enc_dt", enc_dt_o, 32'(dt));
      check("ready_single", 32'(req_ready_o), 0);

      build_bits(dt, mode);
      x     = int'(dt) + 1;
      nb    = floor_log2(x);
      n     = enc_bits.size();
      elen  = (n > 17) ? 17 : n;
      ecode = '0;
      for (int i = 0; i < elen; i++) ecode = {ecode[15:0], enc_bits[i]};
      eerr  = (n == 0) || (n > 17) || (elen != 2*nb + 1) || (int'(ecode) != x);

      if (mode == M_SILENT) begin
         for (int c = 0; c < TIMEOUT; c++) begin
            @(negedge clk); #1;
            check("timeout_not_early", res_valid_o, 0);
            check("start_n_released",  enc_start_n_o, 1);
         end
      end else begin
         repeat (delay) @(negedge clk);
         foreach (enc_bits[b]) begin
            @(negedge clk);
            enc_busy_i = 1'b1;
            enc_cod_i  = enc_bits[b];
         end
         @(negedge clk);
         enc_busy_i = 1'b0;
         enc_cod_i  = 1'b0;
         #1;
      end

      got = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (res_valid_o) begin
            got = 1'b1;
            break;
         end
         @(negedge clk); #1;
      end
      check("result_seen", 32'(got), 1);
      if (!got) return;
      check("res_id",    res_id_o,   32'(exp_id));
      check("res_code",  res_code_o, 32'(ecode));
      check("res_len",   res_len_o,  32'(elen));
      check("res_err",   res_err_o,  32'(eerr));
      check("res_upper", 32'(res_code_o) >> res_len_o, 0);
      check("res_enc_dt", enc_dt_o,  32'(dt));

      for (int s = 0; s < stall; s++) begin
         @(negedge clk); #1;
         check("bp_valid", res_valid_o, 1);
         check("bp_id",    res_id_o,   32'(exp_id));
         check("bp_code",  res_code_o, 32'(ecode));
         check("bp_len",   res_len_o,  32'(elen));
         check("bp_err",   res_err_o,  32'(eerr));
         check("bp_no_grant", 32'(req_ready_o), 0);
      end

      @(negedge clk);
      res_ready_i = 1'b1;
      @(negedge clk);
      res_ready_i = 1'b0;
      model_last  = exp_id;
   endtask

   initial begin
      // Reset with every requester asserting: no strobe may escape.
      rst_n       = 1'b0;
      req_valid_i = '1;
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs();
      req_valid_i = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Round-robin from reset with all four held: 0,1,2,3,0.
      req_dt_i = {8'd30, 8'd7, 8'd1, 8'd12};
      for (int j = 0; j < 5; j++) run_job('1, M_OK, j % TIMEOUT, 0);

      // Single-symbol encodings, including the shortest and longest codes.
      req_dt_i[7:0] = 8'd0;
      run_job(4'b0001, M_OK, 0, 0);
      req_dt_i[7:0] = 8'd4;
      run_job(4'b0001, M_OK, 2, 0);
      req_dt_i[15:8] = 8'd255;
      run_job(4'b0010, M_OK, TIMEOUT - 1, 0);

      // Encoder faults.
      req_dt_i[23:16] = 8'd9;
      run_job(4'b0100, M_SILENT, 0, 0);
      req_dt_i[31:24] = 8'd4;
      run_job(4'b1000, M_LONG, 1, 0);
      req_dt_i[7:0] = 8'd4;
      run_job(4'b0001, M_BAD_PREFIX, 0, 0);
      req_dt_i[15:8] = 8'd100;
      run_job(4'b0010, M_BAD_SUFFIX, 0, 0);
      req_dt_i[23:16] = 8'd255;
      run_job(4'b0100, M_LONG, 0, 0);

      // Backpressure with every requester pending.
      req_dt_i = {8'd63, 8'd2, 8'd200, 8'd17};
      run_job('1, M_OK, 1, 5);

      // Reset in the middle of shifting: abort, no result, priority to 0.
      req_dt_i[23:16] = 8'd50;
      req_valid_i = 4'b0100;
      #1;
      check("mid_grant", 32'(req_ready_o), 32'(1) << model_pick(4'b0100));
      @(negedge clk);
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         enc_busy_i = 1'b1;
         enc_cod_i  = 1'($urandom_range(0, 1));
      end
      #1;
      rst_n      = 1'b0;
      enc_busy_i = 1'b0;
      enc_cod_i  = 1'b0;
      #1;
      check_reset_outputs();
      req_valid_i = '0;
      @(negedge clk); #1;
      check("mid_rst_no_result", res_valid_o, 0);
      @(negedge clk);
      rst_n      = 1'b1;
      model_last = N_REQ - 1;
      @(negedge clk); #1;
      check("post_rst_no_result", res_valid_o, 0);
      req_dt_i = {8'd5, 8'd6, 8'd7, 8'd8};
      run_job('1, M_OK, 0, 0);

      // Randomised traffic.
      for (int j = 0; j < 40; j++) begin
         enc_mode_t m;
         int        r;
         for (int k = 0; k < N_REQ; k++) req_dt_i[k*8 +: 8] = 8'($urandom_range(0, 255));
         r = $urandom_range(0, 9);
         case (r)
            0:       m = M_SILENT;
            1:       m = M_LONG;
            2:       m = M_BAD_PREFIX;
            3:       m = M_BAD_SUFFIX;
            default: m = M_OK;
         endcase
         run_job(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), m,
                 $urandom_range(0, TIMEOUT - 1), $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/expgob_sched.md
EXPGOB_SCHED -- requirements
Module: expgob_sched

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 4, maximum cycles from start pulse to first enc_busy_i.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid_i  input  N_REQ  per-requester symbol valid.
REQ-006 req_dt_i  input  N_REQ*8  per-requester 8-bit symbol; requester k in bits [8k+7:8k].
REQ-007 req_ready_o  output  N_REQ  one-hot accept strobe.
REQ-008 enc_dt_o  output  8  symbol driven to the shared Exp-Golomb (k=0) encoder.
REQ-009 enc_start_n_o  output  1  active-low, one-cycle encoder load pulse.
REQ-010 enc_busy_i  input  1  encoder busy; high while enc_cod_i carries a valid code bit.
REQ-011 enc_cod_i  input  1  serial code bit, MSB first.
REQ-012 res_valid_o, res_ready_i  output/input  1 each  result handshake.
REQ-013 res_id_o  output  3  granted requester index.
REQ-014 res_code_o  output  17  collected code, right-aligned.
REQ-015 res_len_o  output  5  number of collected bits (0..17).
REQ-016 res_err_o  output  1  job failed a check.

Function
REQ-017 The FSM SHALL have the states IDLE, START, WAIT, SHIFT and DONE.
REQ-018 IDLE: with any req_valid_i high, round-robin SHALL grant the first valid index after last_grant (wrapping), raise req_ready_o for that index for that cycle only, latch symbol and id, and go to START.
REQ-019 START: enc_start_n_o SHALL be 0 for exactly one cycle; the FSM then goes to WAIT; enc_dt_o SHALL hold the latched symbol from START through DONE.
REQ-020 WAIT/SHIFT: every cycle with enc_busy_i=1, the code register SHALL shift left with enc_cod_i into bit 0, and len SHALL increment; the first such cycle moves WAIT to SHIFT.
REQ-021 WAIT: if enc_busy_i stays 0 for TIMEOUT cycles, the FSM SHALL go to DONE with err=1 and len=0.
REQ-022 SHIFT: enc_busy_i=0 SHALL move the FSM to DONE; if len reaches 17 while enc_busy_i is still 1, the FSM SHALL go to DONE with err=1 (overflow) and ignore further bits.
REQ-023 DONE: err SHALL also be set if len differs from 2*floor(log2(dt+1))+1 or the code differs from dt+1 (dt=0 -> len 1; dt=255 -> len 17).
REQ-024 DONE: res_valid_o SHALL be held with stable outputs until res_ready_i=1; on that cycle last_grant is updated and the FSM returns to IDLE.
REQ-025 Only one job SHALL be in flight at a time; requests arriving outside IDLE SHALL wait with req_ready_o=0.
REQ-026 Bits of res_code_o above res_len_o SHALL be zero.

Reset
REQ-027 With rst_n=0, the block SHALL immediately enter IDLE, clear the code, length and error registers, and set last_grant=N_REQ-1 so that requester 0 has first priority.
REQ-028 Reset output values SHALL be: req_ready_o=0, enc_start_n_o=1, enc_dt_o=0, res_valid_o=0, res_id_o=0, res_code_o=0, res_len_o=0, res_err_o=0.
REQ-029 A reset in mid-job SHALL abort the job with no result issued.

Verification
REQ-030 Encoding check: req 0, dt=0, bit-accurate encoder model -> id=0, code=1, len=1, err=0; dt=4 -> code=5 (00101), len=5.
REQ-031 Maximum length: dt=255 -> len=17, code=0x00100, err=0.
REQ-032 Round-robin: all four requests valid and held -> grants in order 0,1,2,3,0, each with one req_ready_o pulse.
REQ-033 Timeout: model never asserts busy -> DONE after TIMEOUT=4 WAIT cycles, err=1, len=0.
REQ-034 Faulty model: model emits 18 bits -> err=1, len=17; model emits a wrong prefix -> err=1.
REQ-035 Backpressure and reset: res_ready_i=0 for 5 cycles -> outputs stable, no new grant; rst_n pulse in SHIFT -> all outputs at reset values, next grant goes to requester 0.
